// File: rtl/pc_step_gen_pkg.sv
// pc_step_gen_pkg
// Purpose: shared definitions for the PC step generator. Holds the pulse FSM
//          state encoding, the default timing/debounce parameters and the
//          pulse-start decision used by the FSM.
// Ports:   none (package).
package pc_step_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } pc_state_t;

    localparam int DEF_PULSE_HI  = 2;
    localparam int DEF_GAP       = 12;
    localparam int DEF_DB_CYCLES = 16;

    // A pulse may start from IDLE when free-running, or in step mode with a
    // request pending; halt blocks both. Equivalent to
    // (run & ~halt) | (~run & pending & ~halt).
    function automatic logic start_pulse(input logic run, input logic halt,
                                         input logic pending);
        return ~halt & (run | pending);
    endfunction

endpackage

// File: rtl/pc_step_gen_if.sv
// pc_step_gen_if
// Purpose: groups the control inputs and pulse outputs of pc_step_gen.
// Signals: run, halt, step_btn      - control from the master side
//          PCclk, busy, pulse_done  - pulse status from the generator
//          cycle_count[15:0]        - pulses issued since reset
// Modports: master (drives controls), slave (the generator).
interface pc_step_gen_if;

    logic        run;
    logic        halt;
    logic        step_btn;
    logic        PCclk;
    logic        busy;
    logic        pulse_done;
    logic [15:0] cycle_count;

    modport master (
        output run, halt, step_btn,
        input  PCclk, busy, pulse_done, cycle_count
    );

    modport slave (
        input  run, halt, step_btn,
        output PCclk, busy, pulse_done, cycle_count
    );

endinterface

// File: rtl/pc_step_gen_btn_debounce.sv
// btn_debounce
// Purpose: brings a raw asynchronous push-button into the clk domain through a
//          2-flop synchroniser and debounces it with a run-length counter.
// Ports:   clk, rst (sync, active-high)
//          btn      - raw button input
//          level    - registered debounced level
//          settled  - 1 once level has been confirmed by DB_CYCLES real samples
module btn_debounce
    import pc_step_gen_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic settled
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          last;
    logic [CW-1:0] run_len;
    logic [CW-1:0] run_next;

    // run_len counts consecutive equal synchronised samples, saturating at
    // DB_CYCLES; zero means no sample has been taken since reset.
    always_comb begin
        run_next = CW'(1);
        if (run_len != '0 && sync2 == last) begin
            run_next = (run_len == CW'(DB_CYCLES)) ? run_len : run_len + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            last    <= 1'b0;
            run_len <= '0;
            level   <= 1'b0;
            settled <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            last    <= sync2;
            run_len <= run_next;
            if (run_next == CW'(DB_CYCLES)) begin
                level   <= sync2;
                settled <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_step_gen.sv
// pc_step_gen
// Purpose: generates PC clock pulses of PULSE_HI high cycles followed by GAP
//          low cycles, either free-running (run = 1) or one per debounced
//          step-button press, with halt blocking new pulses.
// Ports:   clk, rst (sync, active-high)
//          bus (pc_step_gen_if.slave): run, halt, step_btn in;
//          PCclk, busy, pulse_done, cycle_count[15:0] out (all registered).
module pc_step_gen
    import pc_step_gen_pkg::*;
#(
    parameter int PULSE_HI  = DEF_PULSE_HI,
    parameter int GAP       = DEF_GAP,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    pc_step_gen_if.slave bus
);

    localparam int CW = $clog2(((PULSE_HI > GAP) ? PULSE_HI : GAP) + 1);

    pc_state_t     state;
    logic [CW-1:0] phase_cnt;
    logic          pc_clk;
    logic          busy_r;
    logic          done_r;
    logic [15:0]   cycle_cnt;

    logic          pending;
    logic          armed;
    logic          level_q;
    logic          db_level;
    logic          db_settled;
    logic          step_rise;
    logic          take_step;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn     (bus.step_btn),
        .level   (db_level),
        .settled (db_settled)
    );

    // Edges are only honoured once the button has been seen debounced low,
    // so a button held through reset cannot trigger a pulse.
    assign step_rise = db_level & ~level_q & armed;
    assign take_step = (state == ST_IDLE) & ~bus.run & pending & ~bus.halt;

    // Single-entry step request. run discards requests outright; a request
    // raised during HIGH/GAP waits and is served from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            armed   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            level_q <= db_level;
            if (db_settled && !db_level) begin
                armed <= 1'b1;
            end
            if (bus.run) begin
                pending <= 1'b0;
            end else if (take_step) begin
                pending <= 1'b0;
            end else if (step_rise) begin
                pending <= 1'b1;
            end
        end
    end

    // Pulse FSM with outputs registered alongside the state. pulse_done is
    // raised on the edge that enters the final GAP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            pc_clk    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cycle_cnt <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start_pulse(bus.run, bus.halt, pending)) begin
                        state     <= ST_HIGH;
                        phase_cnt <= '0;
                        pc_clk    <= 1'b1;
                        busy_r    <= 1'b1;
                        cycle_cnt <= cycle_cnt + 16'd1;
                    end
                end
                ST_HIGH: begin
                    if (phase_cnt == CW'(PULSE_HI - 1)) begin
                        state     <= ST_GAP;
                        phase_cnt <= '0;
                        pc_clk    <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (phase_cnt == CW'(GAP - 1)) begin
                        done_r <= 1'b0;
                        if (bus.run && !bus.halt) begin
                            state     <= ST_HIGH;
                            phase_cnt <= '0;
                            pc_clk    <= 1'b1;
                            cycle_cnt <= cycle_cnt + 16'd1;
                        end else begin
                            state  <= ST_IDLE;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                        done_r    <= (phase_cnt == CW'(GAP - 2));
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    pc_clk <= 1'b0;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PCclk       = pc_clk;
    assign bus.busy        = busy_r;
    assign bus.pulse_done  = done_r;
    assign bus.cycle_count = cycle_cnt;

endmodule

// File: doc/pc_step_gen.md
PC_STEP_GEN -- requirements
Module: pc_step_gen

Interface
REQ-001 Parameter PULSE_HI, default 2: cycles PCclk is held high per pulse (≥1).
REQ-002 Parameter GAP, default 12: cycles PCclk is held low after each pulse before the next pulse (≥11, so the count-5/8/10 phase strobes downstream always complete).
REQ-003 Parameter DB_CYCLES, default 16: consecutive stable samples required by the step-button debouncer.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 run  input  1  level; 1 = free-running pulse generation, 0 = single-step mode.
REQ-007 halt  input  1  level; 1 blocks the start of any new pulse.
REQ-008 step_btn  input  1  raw, bouncy, asynchronous push-button; one debounced rising edge requests one pulse.
REQ-009 PCclk  output  1  registered PC clock pulse driven to the phase-strobe generator.
REQ-010 busy  output  1  1 whenever state ≠ IDLE.
REQ-011 pulse_done  output  1  one-cycle strobe in the last GAP cycle of every pulse.
REQ-012 cycle_count  output  16  number of pulses issued since reset.

Function
REQ-013 FSM states: IDLE, HIGH, GAP; PCclk = 1 exactly when state = HIGH.
REQ-014 IDLE→HIGH when (run & ~halt) or (~run & pending & ~halt); otherwise stays in IDLE.
REQ-015 HIGH lasts exactly PULSE_HI cycles, then →GAP; GAP lasts exactly GAP cycles.
REQ-016 End of GAP: →HIGH directly if run & ~halt (back-to-back period = PULSE_HI+GAP cycles), else →IDLE.
REQ-017 halt and run changes never truncate HIGH or GAP; they are evaluated only in IDLE and at the end of GAP.
REQ-018 step_btn passes through a 2-flop synchroniser and then the debouncer; the debounced level changes only after DB_CYCLES consecutive equal synchronised samples.
REQ-019 A debounced rising edge sets pending (single-entry); further edges while pending = 1 are dropped.
REQ-020 pending clears in the cycle IDLE→HIGH is taken on its behalf; pending is forced to 0 while run = 1 (run has priority, step requests are discarded).
REQ-021 Step edges arriving during HIGH/GAP set pending and are served after GAP completes (minimum pulse spacing is always preserved).
REQ-022 cycle_count increments by 1 on each entry into HIGH, wrapping 16'hFFFF→16'h0000.
REQ-023 Whole-pulse latency: run rising in cycle n → PCclk = 1 in cycles n+1 .. n+PULSE_HI.

Reset
REQ-024 While rst = 1: state = IDLE, PCclk = 0, busy = 0, pulse_done = 0, cycle_count = 0, pending = 0, debouncer counter and level = 0, synchroniser flops = 0.
REQ-025 rst asserted mid-pulse drops PCclk to 0 at the next clock edge; no pulse_done is issued for the aborted pulse.
REQ-026 After rst deasserts, a step_btn already held high produces no pulse until it has been debounced low and then high again.

Structure
REQ-027 Shared package holds the FSM state encoding and the default values of PULSE_HI, GAP and DB_CYCLES.
REQ-028 Sub-module btn_debounce (synchroniser + counter + registered debounced level) is instantiated once; the edge detect and the FSM stay in pc_step_gen.

Verification
REQ-029 Reset: rst high 3 cycles mid-run → PCclk = 0, cycle_count = 0, busy = 0 on the edge after rst is sampled.
REQ-030 Run: run = 1 from cycle 10 → PCclk high in cycles 11–12, 25–26, 39–40; pulse_done in cycles 24 and 38; cycle_count = 3 at cycle 41.
REQ-031 Step with bounce: step_btn toggles every 3 cycles for 30 cycles, then is held high → exactly 1 pulse issued; cycle_count = 1.
REQ-032 Step during pulse: second debounced edge lands in GAP → second pulse starts the cycle after GAP ends; a third edge in the same GAP is dropped.
REQ-033 Halt: halt = 1 asserted in cycle 1 of HIGH with run = 1 → current pulse completes (2 high + 12 low cycles), then IDLE; halt = 0 → next pulse the following cycle.
REQ-034 Wrap: cycle_count preloaded by force to 16'hFFFF, one pulse issued → cycle_count = 0.
